pipelined_alu_adder: RTL and testbench

Parametrised, pipelined successor to the fetch-stage combinational adder. It performs ADD, SUB, ADC or SBC on two WIDTH-bit operands and produces the result plus ARMv8 NZCV flags. The carry chain is split into STAGES registered chunks, and a valid/ready handshake supports backpressure. It serves PC/branch-target generation and the execute-stage integer path, and supports a flush for pipeline redirects.

---
 rtl/pipelined_alu_adder.sv | 115 +++++++++++
 tb/tb_pipelined_alu_adder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_alu_adder.sv
// Pipelined ADD/SUB/ADC/SBC with ARM-style NZCV flags. The carry chain is cut
// into STAGES registered chunks; a valid/ready handshake gives backpressure.
module pipelined_alu_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nzcv
);
  localparam int CW = WIDTH / STAGES;

  // Per-stage state. a_* carries finished low chunks plus untouched high operand
  // chunks of A; b_* carries the effective (possibly inverted) B operand.
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [STAGES-1:0]            c_q, c_d, z_q, z_d, v_q, v_d;
  logic [3:0]                   nzcv_q, nzcv_d;

  logic [STAGES-1:0][WIDTH-1:0] a_src, b_src;
  logic [STAGES-1:0]            c_src, z_src, v_src;

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             stall;
  logic [CW:0]      sum;
  logic             unused_bits;

  assign stall    = v_q[STAGES-1] & ~out_ready;
  assign in_ready = ~stall;

  // op[0] selects subtraction, op[1] selects the external carry-in.
  assign b_eff = op[0] ? ~b : b;
  assign c_eff = op[1] ? cin : op[0];

  assign a_src[0] = a;
  assign b_src[0] = b_eff;
  assign c_src[0] = c_eff;
  assign z_src[0] = 1'b1;
  assign v_src[0] = in_valid;

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign a_src[k] = a_q[k-1];
    assign b_src[k] = b_q[k-1];
    assign c_src[k] = c_q[k-1];
    assign z_src[k] = z_q[k-1];
    assign v_src[k] = v_q[k-1];
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    z_d    = z_q;
    v_d    = v_q;
    nzcv_d = nzcv_q;
    sum    = '0;
    if (flush) begin
      v_d = '0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        sum = {1'b0, a_src[k][k*CW +: CW]} + {1'b0, b_src[k][k*CW +: CW]}
            + {{CW{1'b0}}, c_src[k]};
        a_d[k]             = a_src[k];
        a_d[k][k*CW +: CW] = sum[CW-1:0];
        b_d[k]             = b_src[k];
        c_d[k]             = sum[CW];
        z_d[k]             = z_src[k] & ~|sum[CW-1:0];
        v_d[k]             = v_src[k];
        if (k == STAGES - 1) begin
          // Carry into the MSB is recovered from the MSB sum bit and its operands.
          nzcv_d = {sum[CW-1],
                    z_src[k] & ~|sum[CW-1:0],
                    sum[CW],
                    a_src[k][WIDTH-1] ^ b_src[k][WIDTH-1] ^ sum[CW-1] ^ sum[CW]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      z_q    <= '0;
      v_q    <= '0;
      nzcv_q <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      z_q    <= z_d;
      v_q    <= v_d;
      nzcv_q <= nzcv_d;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign result    = a_q[STAGES-1];
  assign nzcv      = nzcv_q;

  // Last-stage operand B, carry and zero are superseded by result/nzcv.
  assign unused_bits = ^{b_q[STAGES-1], c_q[STAGES-1], z_q[STAGES-1]};

endmodule

// File: tb/tb_pipelined_alu_adder.sv
// Directed bench for pipelined_alu_adder at STAGES=4 (main), 1 and 8.
module tb_pipelined_alu_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [1:0]  op;
  logic [63:0] a, b;
  logic        cin;
  logic        ordy4, ordy_x;

  logic        ir1, ir4, ir8, ov1, ov4, ov8;
  logic [63:0] res1, res4, res8;
  logic [3:0]  nz1, nz4, nz8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_alu_adder #(.WIDTH(64), .STAGES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir4),
    .op(op), .a(a), .b(b), .cin(cin), .out_valid(ov4), .out_ready(ordy4),
    .result(res4), .nzcv(nz4));
  pipelined_alu_adder #(.WIDTH(64), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .op(op), .a(a), .b(b), .cin(cin), .out_valid(ov1), .out_ready(ordy_x),
    .result(res1), .nzcv(nz1));
  pipelined_alu_adder #(.WIDTH(64), .STAGES(8)) u8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir8),
    .op(op), .a(a), .b(b), .cin(cin), .out_valid(ov8), .out_ready(ordy_x),
    .result(res8), .nzcv(nz8));

  typedef struct packed {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] res;
    logic [3:0]  nzcv;
  } vec_t;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ADC = 2'b10, SBC = 2'b11;
  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
    end
  endtask

  // Offer one op for one cycle and watch all three instances for its result.
  task automatic run_vec(input vec_t v, input string name);
    int lat1, lat4, lat8;
    logic [63:0] r1, r4, r8;
    logic [3:0]  f1, f4, f8;
    lat1 = -1; lat4 = -1; lat8 = -1;
    r1 = '0; r4 = '0; r8 = '0; f1 = '0; f4 = '0; f8 = '0;
    @(negedge clk);
    op = v.op; a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (ov1 && lat1 < 0) begin lat1 = n; r1 = res1; f1 = nz1; end
      if (ov4 && lat4 < 0) begin lat4 = n; r4 = res4; f4 = nz4; end
      if (ov8 && lat8 < 0) begin lat8 = n; r8 = res8; f8 = nz8; end
    end
    chk($sformatf("%s s4 latency", name), 64'(lat4), 64'd3);
    chk($sformatf("%s s4 result", name), r4, v.res);
    chk($sformatf("%s s4 nzcv", name), 64'(f4), 64'(v.nzcv));
    chk($sformatf("%s s1 latency", name), 64'(lat1), 64'd0);
    chk($sformatf("%s s1 result", name), r1, v.res);
    chk($sformatf("%s s1 nzcv", name), 64'(f1), 64'(v.nzcv));
    chk($sformatf("%s s8 latency", name), 64'(lat8), 64'd7);
    chk($sformatf("%s s8 result", name), r8, v.res);
    chk($sformatf("%s s8 nzcv", name), 64'(f8), 64'(v.nzcv));
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, " s4 out_valid"}, 64'(ov4), 64'd0);
    chk({name, " s4 result"}, res4, 64'd0);
    chk({name, " s4 nzcv"}, 64'(nz4), 64'd0);
    chk({name, " s4 in_ready"}, 64'(ir4), 64'd1);
    chk({name, " s1 out_valid"}, 64'(ov1), 64'd0);
    chk({name, " s8 out_valid"}, 64'(ov8), 64'd0);
    chk({name, " s8 result"}, res8, 64'd0);
  endtask

  initial begin
    int sent, got, extra, waited;
    logic [63:0] held;
    logic was_stall;

    vecs[0]  = '{ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001};
    vecs[1]  = '{SUB, 64'h5, 64'h5, 1'b0, 64'h0, 4'b0110};
    vecs[2]  = '{SUB, 64'h0, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
    vecs[3]  = '{ADC, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 4'b0110};
    vecs[4]  = '{SBC, 64'h0, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
    vecs[5]  = '{ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 4'b0111};
    vecs[6]  = '{SUB, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
    vecs[7]  = '{ADD, 64'h1, 64'h2, 1'b1, 64'h3, 4'b0000};
    vecs[8]  = '{SUB, 64'hA, 64'h3, 1'b0, 64'h7, 4'b0010};
    vecs[9]  = '{SBC, 64'hA, 64'h3, 1'b1, 64'h7, 4'b0010};
    vecs[10] = '{SBC, 64'hA, 64'h3, 1'b0, 64'h6, 4'b0010};
    vecs[11] = '{ADD, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 4'b0000};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = ADD; a = '0; b = '0; cin = 1'b0;
    ordy4 = 1'b1; ordy_x = 1'b1;
    #1;
    chk_reset_state("reset");
    idle(2);
    rst_n = 1'b1;
    idle(1);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: eight i+i ADDs, consumer stalls for windows 6..8.
    sent = 0; got = 0; was_stall = 1'b0; held = '0;
    for (int w = 0; w < 40 && got < 8; w++) begin
      @(negedge clk);
      ordy4    = !(w >= 6 && w <= 8);
      in_valid = (sent < 8);
      op = ADD; cin = 1'b0;
      a = 64'(sent + 1); b = 64'(sent + 1);
      #1;
      if (was_stall) begin
        chk($sformatf("bp hold w%0d", w), res4, held);
        chk($sformatf("bp hold valid w%0d", w), 64'(ov4), 64'd1);
      end
      chk($sformatf("bp in_ready w%0d", w), 64'(ir4), 64'(!(w >= 6 && w <= 8)));
      if (in_valid && ir4) sent++;
      if (ov4 && ordy4) begin
        chk($sformatf("bp result %0d", got), res4, 64'(2 * (got + 1)));
        got++;
      end
      was_stall = ov4 && !ordy4;
      held = res4;
    end
    chk("bp count", 64'(got), 64'd8);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      ordy4 = 1'b1;
      #1;
      if (ov4) extra++;
    end
    chk("bp no duplicate", 64'(extra), 64'd0);
    idle(10);

    // Flush with three ops in flight and a fourth offered alongside flush.
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      in_valid = 1'b1; op = ADD; cin = 1'b0;
      a = 64'(w + 10); b = 64'h1;
      flush = (w == 3);
    end
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk($sformatf("flush s4 out_valid +%0d", n), 64'(ov4), 64'd0);
      chk($sformatf("flush s1 out_valid +%0d", n), 64'(ov1), 64'd0);
      chk($sformatf("flush s8 out_valid +%0d", n), 64'(ov8), 64'd0);
    end
    idle(4);
    run_vec('{ADD, 64'h3, 64'h4, 1'b0, 64'h7, 4'b0000}, "post-flush");

    // Asynchronous reset while a result is held under backpressure.
    @(negedge clk);
    ordy4 = 1'b0; in_valid = 1'b1; op = ADD; cin = 1'b0;
    a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'h1;
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    while (!ov4 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("pre-reset out_valid", 64'(ov4), 64'd1);
    chk("pre-reset result", res4, 64'h8000_0000_0000_0000);
    chk("pre-reset nzcv", 64'(nz4), 64'b1001);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    ordy4 = 1'b1;
    run_vec(vecs[0], "after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
